pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Program-counter sequencer for the MIPS fetch stage. Holds the PC and drives instruction-fetch requests.
//  Selects the next PC from three sources: sequential, branch target (base + sext(imm)<<2),
//  and jump / jump-register. Sequences redirects against a fetch handshake with stall support.
//  Sits between decode/branch-resolve logic and instruction memory.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; low 2 bits must be 0
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  stall        in   1   pipeline stall; PC holds, no new fetch request
//  fetch_req    out  1   fetch request to instruction memory
//  fetch_addr   out  32  fetch address (= pc)
//  fetch_ack    in   1   memory accepted fetch_addr this cycle
//  br_taken     in   1   1-cycle pulse: conditional branch resolved taken
//  br_base      in   32  PC+4 of the branch instruction
//  br_imm       in   16  branch immediate (word offset)
//  jmp          in   1   1-cycle pulse: J/JAL
//  jmp_index    in   26  jump instruction index
//  jr           in   1   1-cycle pulse: JR/JALR
//  jr_target    in   32  register target
//  pc           out  32  current PC
//  pc_plus4     out  32  pc + 4 (wraps modulo 2^32)
//  addr_err     out  1   sticky; set when jr_target[1:0] != 0
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, fetch_req=0, addr_err=0, pending=0, state=IDLE.
//  FSM states:
//   - IDLE  -> FETCH unconditionally on the first clock after reset release.
//   - FETCH -> STALL when stall=1; otherwise stays in FETCH.
//   - STALL -> FETCH when stall=0.
//  fetch_req = (state==FETCH) && !stall. fetch_addr = pc.
//  Advance happens only on the cycle with fetch_req && fetch_ack:
//   - pc <= pending ? pend_tgt : pc_plus4
//   - pending is cleared.
//  Redirect targets (arithmetic is 32-bit and wraps; no overflow detection):
//   - branch: br_base + {{14{br_imm[15]}}, br_imm, 2'b00}
//   - jump:   {br_base[31:28], jmp_index, 2'b00}
//   - jr:     {jr_target[31:2], 2'b00}; addr_err <= 1 if jr_target[1:0] != 0
//  Priority among simultaneous pulses: jr > jmp > br_taken.
//  Every redirect pulse is captured into pend_tgt and sets pending, regardless of ack or stall.
//  A later redirect pulse overwrites an earlier one that is still pending.
//  A redirect pulse in the same cycle as an ack:
//   - the new target is captured (pending=1);
//   - the acked address is still pc_plus4 or the old pending target;
//   - the new target applies on the next ack.
//  Stall freezes pc, pending and pend_tgt but does not block redirect capture.
//  Reset mid-operation aborts any fetch and discards pending.
//  addr_err is cleared only by reset.
// CONFIGURATION
//  PC_DELAY_SLOT_EN defined (MIPS delay-slot semantics):
//   - a redirect is applied one ack later; the first ack after capture advances to pc_plus4
//     (delay slot), and the second ack loads pend_tgt;
//   - adds a 1-bit slot_done flag;
//   - a new redirect during the slot restarts the slot count.
//  PC_DELAY_SLOT_EN undefined: a redirect applies on the first ack after capture (behaviour as above).
// STRUCTURE
//  Shared package mips_pkg:
//   - pc_state_t enum {IDLE, FETCH, STALL}
//   - PC_W=32, IMM_W=16, JIDX_W=26
//   - function sext_shl2(imm) -> 32-bit
//  Sub-module pc_target_calc (combinational): branch/jump/jr target selection and priority mux.
//  pc_sequencer keeps the FSM, pc, pending, pend_tgt and addr_err registers.
// TESTING
//  1. Reset release, fetch_ack=1 every cycle:
//     fetch_req rises 1 cycle after release; pc runs 0x0,0x4,0x8,0xC.
//  2. Branch at pc=0x100: br_base=0x104, br_imm=16'hFFFE, ack every cycle:
//     the next pc after one more ack is 0x0FC (0x100 without PC_DELAY_SLOT_EN applies 0x0FC directly).
//  3. jr and jmp asserted together with jr_target=0x2001:
//     target 0x2000 wins; addr_err=1 and stays set until rst_n=0.
//  4. stall=1 for 3 cycles, with br_taken pulsed mid-stall (target 0x400):
//     fetch_req=0 and pc frozen; on release the first ack loads 0x400.
//  5. fetch_ack held 0 for 4 cycles while two redirects arrive (0x500, then 0x600):
//     on ack pc=0x600; 0x500 is never fetched.
//  6. rst_n pulsed low while pending=1 and fetch_req=1:
//     outputs return to reset values immediately; pc=RESET_PC after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS fetch-stage PC sequencer.
// Target arithmetic here is plain 32-bit wrapping math.
package mips_pkg;

    localparam int PC_W   = 32;
    localparam int IMM_W  = 16;
    localparam int JIDX_W = 26;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STALL
    } pc_state_t;

    function automatic logic [PC_W-1:0] sext_shl2(input logic [IMM_W-1:0] imm);
        return {{(PC_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target selection: jr beats jmp beats a taken branch.
// Also flags a misaligned register target.
module pc_target_calc
    import mips_pkg::*;
(
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_base,
    input  logic [IMM_W-1:0]  br_imm,
    input  logic              jmp,
    input  logic [JIDX_W-1:0] jmp_index,
    input  logic              jr,
    input  logic [PC_W-1:0]   jr_target,
    output logic              redir,
    output logic [PC_W-1:0]   tgt,
    output logic              misalign
);

    always_comb begin
        redir    = jr | jmp | br_taken;
        tgt      = '0;
        misalign = 1'b0;
        if (jr) begin
            tgt      = {jr_target[PC_W-1:2], 2'b00};
            misalign = |jr_target[1:0];
        end else if (jmp) begin
            tgt = {br_base[PC_W-1:PC_W-4], jmp_index, 2'b00};
        end else if (br_taken) begin
            tgt = br_base + sext_shl2(br_imm);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: FSM, PC, pending redirect and sticky addr_err.
// Define PC_DELAY_SLOT_EN for MIPS delay-slot redirect timing.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    output logic              fetch_req,
    output logic [PC_W-1:0]   fetch_addr,
    input  logic              fetch_ack,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_base,
    input  logic [IMM_W-1:0]  br_imm,
    input  logic              jmp,
    input  logic [JIDX_W-1:0] jmp_index,
    input  logic              jr,
    input  logic [PC_W-1:0]   jr_target,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_plus4,
    output logic              addr_err
);

    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
    logic            pending_q, pending_d;
    logic            addr_err_q, addr_err_d;
    logic            redir, misalign, fire;
    logic [PC_W-1:0] tgt;
`ifdef PC_DELAY_SLOT_EN
    logic            slot_done_q, slot_done_d;
`endif

    pc_target_calc u_calc (
        .br_taken  (br_taken),
        .br_base   (br_base),
        .br_imm    (br_imm),
        .jmp       (jmp),
        .jmp_index (jmp_index),
        .jr        (jr),
        .jr_target (jr_target),
        .redir     (redir),
        .tgt       (tgt),
        .misalign  (misalign)
    );

    assign pc         = pc_q;
    assign pc_plus4   = pc_q + 32'd4;
    assign fetch_addr = pc_q;
    assign fetch_req  = (state_q == FETCH) && !stall;
    assign addr_err   = addr_err_q;
    assign fire       = fetch_req && fetch_ack;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        pend_tgt_d = pend_tgt_q;
        addr_err_d = addr_err_q | misalign;
`ifdef PC_DELAY_SLOT_EN
        slot_done_d = slot_done_q;
`endif
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = stall ? STALL : FETCH;
            STALL:   state_d = stall ? STALL : FETCH;
            default: state_d = IDLE;
        endcase
        if (fire) begin
`ifdef PC_DELAY_SLOT_EN
            // First ack after capture fetches the delay slot.
            if (pending_q && slot_done_q) begin
                pc_d        = pend_tgt_q;
                pending_d   = 1'b0;
                slot_done_d = 1'b0;
            end else begin
                pc_d = pc_plus4;
                if (pending_q) slot_done_d = 1'b1;
            end
`else
            pc_d      = pending_q ? pend_tgt_q : pc_plus4;
            pending_d = 1'b0;
`endif
        end
        // A new redirect wins over anything the ack just consumed.
        if (redir) begin
            pending_d  = 1'b1;
            pend_tgt_d = tgt;
`ifdef PC_DELAY_SLOT_EN
            slot_done_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pending_q  <= 1'b0;
            pend_tgt_q <= '0;
            addr_err_q <= 1'b0;
`ifdef PC_DELAY_SLOT_EN
            slot_done_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            pend_tgt_q <= pend_tgt_d;
            addr_err_q <= addr_err_d;
`ifdef PC_DELAY_SLOT_EN
            slot_done_q <= slot_done_d;
`endif
        end
    end

endmodule
